// File: rtl/bcd_event_counter_pkg.sv
// Shared types and constants for the BCD event counter.
// The optional macro BCD_DOWN_COUNT_EN adds an up/down control port to bcd_event_counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // True for the ten legal BCD codes 0..9.
    function automatic logic bcd_is_legal(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_event_counter_digit.sv
// One BCD decade: steps up or down on cnt_in, wraps 9<->0 and
// raises cnt_out in the same cycle so the cascade ripples combinationally.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       cnt_in,
    input  logic       dir,
    output bcd_digit_t q,
    output logic       cnt_out
);

    // Carry (up) leaves on 9, borrow (down) leaves on 0; an illegal code never propagates.
    always_comb begin
        cnt_out = 1'b0;
        if (cnt_in) begin
            cnt_out = dir ? (q == BCD_MAX) : (q == BCD_MIN);
        end
    end

    // Decade register: clear wins over stepping, illegal codes collapse to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (clear) begin
            q <= BCD_MIN;
        end else if (cnt_in) begin
            if (!bcd_is_legal(q)) begin
                q <= BCD_MIN;
            end else if (dir) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_event_counter.sv
// Cascaded BCD event counter with one-cycle wrap pulse and sticky overflow.
// Define BCD_DOWN_COUNT_EN to add the up_dn input (1=up, 0=down); otherwise up-count only.
module bcd_event_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_n,
    input  logic                    clear,
    input  logic                    hold,
`ifdef BCD_DOWN_COUNT_EN
    input  logic                    up_dn,
`endif
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    carry_out,
    output logic                    overflow
);

    logic              dir;
    logic              advance_p0;
    logic [NUM_DIGITS:0] cnt_chain;
    logic              carry_p1;
    logic              overflow_p1;

`ifdef BCD_DOWN_COUNT_EN
    assign dir = up_dn;
`else
    assign dir = 1'b1;
`endif

    // Stage p0: a strobe counts only when neither clear nor hold is active; held strobes are dropped.
    always_comb begin
        advance_p0 = !enable_n && !hold && !clear;
    end

    assign cnt_chain[0] = advance_p0;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_decade
            bcd_digit u_digit (
                .clk     (clk),
                .reset   (reset),
                .clear   (clear),
                .cnt_in  (cnt_chain[g]),
                .dir     (dir),
                .q       (digits[4*g +: 4]),
                .cnt_out (cnt_chain[g+1])
            );
        end
    endgenerate

    // Stage p1: the last decade's carry/borrow becomes the wrap pulse and sets the sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_p1    <= 1'b0;
            overflow_p1 <= 1'b0;
        end else if (clear) begin
            carry_p1    <= 1'b0;
            overflow_p1 <= 1'b0;
        end else begin
            carry_p1    <= cnt_chain[NUM_DIGITS];
            overflow_p1 <= overflow_p1 | cnt_chain[NUM_DIGITS];
        end
    end

    assign carry_out = carry_p1;
    assign overflow  = overflow_p1;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: integer reference model compared every cycle, plus literal spot checks.
module tb_bcd_event_counter;

    localparam int ND   = 4;
    localparam int MAXV = 9999;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable_n = 1'b1;
    logic            clear = 1'b0;
    logic            hold = 1'b0;
    logic            up_dn = 1'b1;
    logic [4*ND-1:0] digits;
    logic            carry_out;
    logic            overflow;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int m_cnt   = 0;
    bit m_carry = 1'b0;
    bit m_ovf   = 1'b0;

    always #5 clk = ~clk;

    bcd_event_counter #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable_n  (enable_n),
        .clear     (clear),
        .hold      (hold),
`ifdef BCD_DOWN_COUNT_EN
        .up_dn     (up_dn),
`endif
        .digits    (digits),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference model: the count is a plain integer modulo 10^ND.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_carry <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (clear) begin
            m_cnt   <= 0;
            m_carry <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (!hold && !enable_n) begin
            if (up_dn) begin
                if (m_cnt == MAXV) begin
                    m_cnt <= 0; m_carry <= 1'b1; m_ovf <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1; m_carry <= 1'b0;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_cnt <= MAXV; m_carry <= 1'b1; m_ovf <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1; m_carry <= 1'b0;
                end
            end
        end else begin
            m_carry <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("model_digits", 32'(digits), 32'(to_bcd(m_cnt)));
            check("model_carry", 32'(carry_out), 32'(m_carry));
            check("model_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic step(input logic en_n, input logic hd, input logic clr);
        @(negedge clk);
        enable_n = en_n;
        hold     = hd;
        clear    = clr;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        reset = 1'b1;
        #12;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_carry", 32'(carry_out), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        // Twelve isolated pulses.
        pulses(12);
        idle();
        check("twelve_pulses", 32'(digits), 32'h0012);

        // Twenty-five back-to-back strobes.
        do_clear();
        strobes(25);
        idle();
        check("run_of_25", 32'(digits), 32'h0025);

        // Preload to 9998, then step across the wrap.
        do_clear();
        strobes(9998);
        idle();
        check("preload_9998", 32'(digits), 32'h9998);
        step(1'b0, 1'b0, 1'b0);
        idle();
        check("at_9999", 32'(digits), 32'h9999);
        check("no_carry_9999", 32'(carry_out), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        idle();
        check("wrap_digits", 32'(digits), 32'h0000);
        check("wrap_carry", 32'(carry_out), 32'h1);
        check("wrap_ovf", 32'(overflow), 32'h1);
        idle();
        check("carry_one_cycle", 32'(carry_out), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Hold drops strobes.
        pulses(3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        idle();
        check("hold_unchanged", 32'(digits), 32'h0003);
        check("hold_ovf_kept", 32'(overflow), 32'h1);

        // Clear beats a simultaneous strobe.
        step(1'b0, 1'b0, 1'b1);
        idle();
        check("clear_digits", 32'(digits), 32'h0000);
        check("clear_ovf", 32'(overflow), 32'h0);
        check("clear_carry", 32'(carry_out), 32'h0);

        // Asynchronous reset between edges at 457.
        strobes(457);
        idle();
        check("at_0457", 32'(digits), 32'h0457);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_digits", 32'(digits), 32'h0);
        check("async_rst_ovf", 32'(overflow), 32'h0);
        #1;
        reset = 1'b0;
        pulses(1);
        idle();
        check("after_reset_one", 32'(digits), 32'h0001);

`ifdef BCD_DOWN_COUNT_EN
        do_clear();
        up_dn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        idle();
        check("down_wrap_digits", 32'(digits), 32'h9999);
        check("down_wrap_carry", 32'(carry_out), 32'h1);
        check("down_wrap_ovf", 32'(overflow), 32'h1);
        up_dn = 1'b1;
        do_clear();
        strobes(100);
        idle();
        up_dn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        idle();
        check("down_0100", 32'(digits), 32'h0099);
        up_dn = 1'b1;
`endif

        // Randomized traffic checked by the model every cycle.
        do_clear();
        strobes(9990);
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 199) == 0));
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_event_counter.md
BCD_EVENT_COUNTER -- requirements
Module: bcd_event_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of cascaded BCD decades (legal range 1..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable_n  input  1  active-low count strobe from the clock divider, synchronous to clk; low for one cycle per divided tick.
REQ-005 clear  input  1  synchronous clear of count and overflow, active-high.
REQ-006 hold  input  1  active-high freeze; count unchanged while high.
REQ-007 digits  output  4*NUM_DIGITS  BCD count; bits [3:0] are decade 0 (least significant).
REQ-008 carry_out  output  1  one-cycle pulse on wrap-around.
REQ-009 overflow  output  1  sticky flag, set on first wrap-around.

Function
REQ-010 The counter SHALL advance by one on every rising clk edge where enable_n==0, hold==0, clear==0.
REQ-011 Each decade SHALL count 0..9 only; on 9 with carry-in it SHALL go to 0 and carry into the next decade in the same cycle.
REQ-012 Digits SHALL be registered; the new value SHALL be visible the cycle after the qualifying enable_n edge (latency 1).
REQ-013 When all decades are 9 and the count advances, digits SHALL become all 0, carry_out SHALL be 1 for exactly that one cycle, overflow SHALL be set.
REQ-014 carry_out SHALL be registered and SHALL be 0 in every other cycle.
REQ-015 overflow SHALL remain 1 until clear or reset.
REQ-016 Priority SHALL be reset > clear > hold > count; clear with enable_n==0 yields all-zero digits, carry_out 0.
REQ-017 hold==1 with enable_n==0 SHALL drop that strobe (no deferred count).
REQ-018 enable_n held low for N consecutive cycles SHALL advance the count by N.
REQ-019 Any digit holding an illegal code (10..15) SHALL be forced to 0 on the next count advance, with no carry from it.

Reset
REQ-020 On reset assertion all digits, carry_out and overflow SHALL go to 0 immediately, independent of clk.
REQ-021 Reset asserted mid-count SHALL discard the count; the first advance after release SHALL produce 1.
REQ-022 The first clk edge after reset deassertion SHALL obey REQ-016 normally.

Configuration
REQ-023 Macro BCD_DOWN_COUNT_EN SHALL compile in an input port up_dn (1 bit; 1=up, 0=down).
REQ-024 With BCD_DOWN_COUNT_EN defined and up_dn==0, each decade SHALL count 9..0; on 0 with borrow it SHALL go to 9 and borrow from the next decade.
REQ-025 With BCD_DOWN_COUNT_EN defined, all-zero counting down SHALL wrap to all 9s, pulse carry_out and set overflow.
REQ-026 Without BCD_DOWN_COUNT_EN the up_dn port SHALL not exist and behaviour SHALL be up-count only.

Structure
REQ-027 Package bcd_pkg SHALL hold typedef bcd_digit_t (4-bit logic), constants BCD_MAX=9 and BCD_MIN=0.
REQ-028 Sub-module bcd_digit SHALL implement one decade with inputs clk, reset, clear, cnt_in (carry/borrow in), dir; outputs q, cnt_out; instantiated NUM_DIGITS times via generate.
REQ-029 carry_out/overflow logic SHALL live in the top module, derived from the last decade's cnt_out.

Verification
REQ-030 Reset, then 12 single-cycle enable_n low pulses -> digits 0x0012, carry_out never 1.
REQ-031 Preload to 0x9998 via strobes (or force), two pulses -> 0x9999 then 0x0000 with carry_out high one cycle, overflow 1 until clear.
REQ-032 hold=1 during 5 pulses -> digits unchanged; clear=1 with enable_n=0 -> 0x0000, overflow 0.
REQ-033 enable_n low 25 consecutive cycles from 0 -> 0x0025.
REQ-034 Reset asserted between clk edges at 0x0457 -> outputs 0 before next edge; next pulse -> 0x0001.
REQ-035 With BCD_DOWN_COUNT_EN, up_dn=0 from 0x0000, one pulse -> 0x9999, carry_out pulse, overflow 1; from 0x0100 one pulse -> 0x0099.
